wb_lsu_master: RTL
==================

# wb_lsu_master

Wishbone B4-classic initiator serving the core's load/store path on the data bus (dwb_*). Accepts one load or store request at a time from the execute stage, encoded by RV32I funct3. Generates the word-aligned address, byte-lane select and replicated store data, then waits for ack, err or a bus timeout. Returns aligned, sign- or zero-extended load data and error status. It is the initiator counterpart of the unified-memory responder used by the compliance benches.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles stb is held without ack/err; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-order bytes used
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access failed (misaligned, illegal funct3, bus err, or timeout)
- rsp_misaligned  out  1  address misaligned for the access size
- rsp_timeout  out  1  bus timeout occurred
- dwb_adr_o  out  32  {addr[31:2],2'b00}
- dwb_dat_o  out  32  replicated store data
- dwb_dat_i  in  32  read data, valid in the same cycle as ack
- dwb_we_o  out  1  write enable
- dwb_sel_o  out  4  byte lanes
- dwb_cyc_o, dwb_stb_o  out  1  cycle and strobe, always equal
- dwb_ack_i, dwb_err_i  in  1  termination

## Operation
- FSM states: IDLE, BUS, RESP. All outputs are registered except req_ready, which is (state==IDLE).
- IDLE, req_valid=1: decode and check the request.
  - Illegal funct3 (load 3/6/7, store >2) -> RESP with rsp_err=1.
  - Misaligned (half: addr[0]; word: addr[1:0]≠0) -> RESP with rsp_err=1 and rsp_misaligned=1.
  - Either case: no bus cycle is issued.
  - Otherwise latch adr, sel, we, dat, funct3 and addr[1:0]; assert cyc/stb; go to BUS.
- Select: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111. Loads drive sel identically.
- Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- BUS: cyc, stb, adr, sel, we and dat are held stable until termination.
  - err=1 -> rsp_err=1. err has priority over a simultaneous ack.
  - ack=1 -> capture the extracted load data.
  - Timeout counter (cleared on BUS entry) reaching TIMEOUT_CYCLES-1 with no termination -> rsp_err=1, rsp_timeout=1.
  - On any termination: deassert cyc/stb and go to RESP.
- Load extraction: byte = dat_i>>(8*addr[1:0]), half = dat_i>>(16*addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes dat_i through.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_* hold their values until the next RESP; flags are cleared on request acceptance.

## Timing
- Reset values: cyc/stb/we=0, adr/dat/sel=0, rsp_valid/rsp_err/rsp_misaligned/rsp_timeout=0, rsp_rdata=0, state IDLE (so req_ready=1).
- Edge E0 accepts the request; cyc/stb are high from E0.
- A responder with registered ack (ack after E1) is sampled at E2. rsp_valid is high E2–E3. req_ready returns after E3.
- A responder with combinational ack is sampled at E1.
- A failed misalignment/funct3 check gives rsp_valid after E1 with no cyc.
- stb is never high for more than TIMEOUT_CYCLES cycles.
- ack/err are ignored outside BUS.
- Reset asserted mid-BUS drops cyc/stb immediately; no rsp_valid is produced.

## Test plan
- SB addr 0x1001 wdata 0x123456AB -> adr 0x1000, sel 0010, dat_o 0xABABABAB, we=1; rsp_valid 2 cycles after accept with 1-cycle ack; rsp_rdata 0.
- LH/LHU addr 0x0102, dat_i 0x80011234 -> sel 1100; rsp_rdata 0xFFFF8001 / 0x00008001. LB addr 0x0103 -> 0xFFFFFF80.
- LW addr 0x1002 -> no cyc; rsp_valid one cycle after accept with rsp_err=1 and rsp_misaligned=1. Load funct3=3 -> rsp_err=1, rsp_misaligned=0.
- Responder asserts ack and err together on SW -> rsp_err=1, rsp_timeout=0, cyc low next cycle.
- TIMEOUT_CYCLES=16, responder never acks -> stb high exactly 16 cycles, then rsp_err=1 and rsp_timeout=1. Back-to-back LW succeeds afterwards.
- rst_n pulsed low while in BUS -> cyc/stb=0 asynchronously, rsp_valid stays 0, req_ready=1 after release.

Source files
------------

// File: rtl/wb_lsu_master.sv
// Wishbone B4-classic load/store initiator: one request at a time, bus termination by ack, err or timeout.
// Latency: a legal request holds stb until termination, then pulses rsp_valid; a failed pre-check responds one cycle after acceptance.
module wb_lsu_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_misaligned,
    output logic        rsp_timeout,
    output logic [31:0] dwb_adr_o,
    output logic [31:0] dwb_dat_o,
    input  logic [31:0] dwb_dat_i,
    output logic        dwb_we_o,
    output logic [3:0]  dwb_sel_o,
    output logic        dwb_cyc_o,
    output logic        dwb_stb_o,
    input  logic        dwb_ack_i,
    input  logic        dwb_err_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        fail_pend;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic [31:0] tmo_cnt;

    logic        illegal;
    logic        misal;
    logic [3:0]  sel_d;
    logic [31:0] dat_d;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    assign req_ready = (state == IDLE);
    assign dwb_stb_o = dwb_cyc_o;

    always_comb begin
        illegal = req_we ? (req_funct3 > 3'd2)
                         : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
        misal   = 1'b0;
        sel_d   = 4'b1111;
        dat_d   = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                sel_d = 4'b0001 << req_addr[1:0];
                dat_d = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                sel_d = 4'b0011 << {req_addr[1], 1'b0};
                dat_d = {2{req_wdata[15:0]}};
                misal = req_addr[0];
            end
            2'd2: misal = (req_addr[1:0] != 2'b00);
            default: ;
        endcase
        // An illegal encoding reports only as an error, never as misaligned.
        if (illegal)
            misal = 1'b0;
    end

    always_comb begin
        case (ld_off)
            2'd0:    byte_v = dwb_dat_i[7:0];
            2'd1:    byte_v = dwb_dat_i[15:8];
            2'd2:    byte_v = dwb_dat_i[23:16];
            default: byte_v = dwb_dat_i[31:24];
        endcase
        half_v = ld_off[1] ? dwb_dat_i[31:16] : dwb_dat_i[15:0];
        case (ld_f3)
            3'd0:    load_v = {{24{byte_v[7]}}, byte_v};
            3'd1:    load_v = {{16{half_v[15]}}, half_v};
            3'd2:    load_v = dwb_dat_i;
            3'd4:    load_v = {24'd0, byte_v};
            3'd5:    load_v = {16'd0, half_v};
            default: load_v = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            fail_pend      <= 1'b0;
            ld_f3          <= 3'd0;
            ld_off         <= 2'd0;
            tmo_cnt        <= 32'd0;
            dwb_cyc_o      <= 1'b0;
            dwb_we_o       <= 1'b0;
            dwb_adr_o      <= 32'd0;
            dwb_dat_o      <= 32'd0;
            dwb_sel_o      <= 4'd0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_err        <= 1'b0;
            rsp_misaligned <= 1'b0;
            rsp_timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        rsp_err        <= illegal | misal;
                        rsp_misaligned <= misal;
                        rsp_timeout    <= 1'b0;
                        tmo_cnt        <= 32'd0;
                        state          <= BUS;
                        // Failed pre-checks pass through BUS without a cycle so the response timing stays uniform.
                        if (illegal || misal) begin
                            fail_pend <= 1'b1;
                        end else begin
                            fail_pend <= 1'b0;
                            dwb_cyc_o <= 1'b1;
                            dwb_we_o  <= req_we;
                            dwb_adr_o <= {req_addr[31:2], 2'b00};
                            dwb_sel_o <= sel_d;
                            dwb_dat_o <= dat_d;
                            ld_f3     <= req_funct3;
                            ld_off    <= req_addr[1:0];
                        end
                    end
                end
                BUS: begin
                    if (fail_pend) begin
                        fail_pend <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (dwb_err_i) begin
                        dwb_cyc_o <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'd0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (dwb_ack_i) begin
                        dwb_cyc_o <= 1'b0;
                        rsp_rdata <= dwb_we_o ? 32'd0 : load_v;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TIMEOUT_CYCLES - 1) begin
                        dwb_cyc_o   <= 1'b0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= 32'd0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
